// File: rtl/pid_multichannel.sv
// Multichannel PID controller. One shared arithmetic datapath is time-shared
// across CH channels. Each channel keeps its own integrator and previous-error
// register. A sample is accepted in IDLE and its result is computed in CALC.
// The result is then held in OUT until the consumer takes it.
module pid_multichannel #(
  parameter int CH     = 2,
  parameter int DATA_W = 6,
  parameter int GAIN_W = 6,
  parameter int ACC_W  = 12,
  parameter int SHIFT  = 0,
  localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   e_valid,
  output logic                   e_ready,
  input  logic [CH_W-1:0]        e_ch,
  input  logic [DATA_W-1:0]      e,
  input  logic [2*CH-1:0]        mode,
  input  logic [CH*GAIN_W-1:0]   K_p,
  input  logic [CH*GAIN_W-1:0]   K_i,
  input  logic [CH*GAIN_W-1:0]   K_d,
  input  logic [CH-1:0]          clr,
  output logic                   u_valid,
  input  logic                   u_ready,
  output logic [CH_W-1:0]        u_ch,
  output logic [DATA_W-1:0]      u,
  output logic                   sat
);

  // Widest signed operand feeding a gain multiplier (integrator or difference)
  localparam int MAG_W = (ACC_W > DATA_W + 1) ? ACC_W : DATA_W + 1;
  // Room for three products plus carries so the sum can never overflow
  localparam int SUM_W = GAIN_W + MAG_W + 3;

  localparam logic signed [SUM_W-1:0] U_MAX = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] U_MIN = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t                    state;
  logic                      started;

  logic signed [DATA_W-1:0]  e_p0;
  logic [CH_W-1:0]           ch_p0;
  logic [1:0]                mode_p0;
  logic [GAIN_W-1:0]         kp_p0, ki_p0, kd_p0;

  logic signed [ACC_W-1:0]   integ  [CH];
  logic signed [DATA_W-1:0]  e_prev [CH];

  logic [CH_W-1:0]           ch_sel;
  logic signed [DATA_W:0]    e_x, ep_x, diff_c;
  logic signed [ACC_W:0]     isum_c;
  logic signed [ACC_W-1:0]   i_c;
  logic signed [SUM_W-1:0]   kp_x, ki_x, kd_x, e_sx, ic_sx, d_sx;
  logic signed [SUM_W-1:0]   p_t, i_t, d_t, sum_c, shf_c;
  logic                      clip_hi, clip_lo, i_commit;
  logic [DATA_W-1:0]         u_c;

  // Clamp a one-bit-overflowed integrator sum back into the ACC_W signed range
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] v);
    if (v[ACC_W] != v[ACC_W-1])
      sat_acc = v[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      sat_acc = v[ACC_W-1:0];
  endfunction

  // Clamp the shifted gain sum into the DATA_W signed output range
  function automatic logic [DATA_W-1:0] sat_out(input logic signed [SUM_W-1:0] v);
    if (v > U_MAX)
      sat_out = {1'b0, {(DATA_W-1){1'b1}}};
    else if (v < U_MIN)
      sat_out = {1'b1, {(DATA_W-1){1'b0}}};
    else
      sat_out = v[DATA_W-1:0];
  endfunction

  assign e_ready = started && ena && (state == IDLE);

  // Out-of-range channel numbers alias onto the last channel
  always_comb begin
    ch_sel = e_ch;
    if (int'(e_ch) > CH - 1)
      ch_sel = CH_W'(CH - 1);
  end

  // Datapath for the captured sample: difference, integrator, gain sum, clip
  always_comb begin
    e_x     = {e_p0[DATA_W-1], e_p0};
    ep_x    = {e_prev[ch_p0][DATA_W-1], e_prev[ch_p0]};
    diff_c  = e_x - ep_x;
    isum_c  = {integ[ch_p0][ACC_W-1], integ[ch_p0]}
            + {{(ACC_W+1-DATA_W){e_p0[DATA_W-1]}}, e_p0};
    i_c     = sat_acc(isum_c);
    kp_x    = {{(SUM_W-GAIN_W){1'b0}}, kp_p0};
    ki_x    = {{(SUM_W-GAIN_W){1'b0}}, ki_p0};
    kd_x    = {{(SUM_W-GAIN_W){1'b0}}, kd_p0};
    e_sx    = {{(SUM_W-DATA_W){e_p0[DATA_W-1]}}, e_p0};
    ic_sx   = {{(SUM_W-ACC_W){i_c[ACC_W-1]}}, i_c};
    d_sx    = {{(SUM_W-DATA_W-1){diff_c[DATA_W]}}, diff_c};
    p_t     = kp_x * e_sx;
    i_t     = mode_p0[0] ? ki_x * ic_sx : '0;
    d_t     = mode_p0[1] ? kd_x * d_sx  : '0;
    sum_c   = p_t + i_t + d_t;
    shf_c   = sum_c >>> SHIFT;
    clip_hi = shf_c > U_MAX;
    clip_lo = shf_c < U_MIN;
    u_c     = sat_out(shf_c);
    // Conditional integration: hold the integrator while it would push further into the clip
    i_commit = mode_p0[0] && !((clip_hi && !e_p0[DATA_W-1]) || (clip_lo && e_p0[DATA_W-1]));
  end

  // Capture stage boundary: sample, channel, mode and that channel's gains
  always_ff @(posedge clk) begin
    if (ena && e_valid && e_ready) begin
      e_p0    <= e;
      ch_p0   <= ch_sel;
      mode_p0 <= mode[2*int'(ch_sel) +: 2];
      kp_p0   <= K_p[int'(ch_sel)*GAIN_W +: GAIN_W];
      ki_p0   <= K_i[int'(ch_sel)*GAIN_W +: GAIN_W];
      kd_p0   <= K_d[int'(ch_sel)*GAIN_W +: GAIN_W];
    end
  end

  // Control FSM with registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      started <= 1'b0;
      u_valid <= 1'b0;
      u       <= '0;
      u_ch    <= '0;
      sat     <= 1'b0;
    end else if (ena) begin
      started <= 1'b1;
      case (state)
        IDLE: if (e_valid && e_ready) state <= CALC;
        CALC: begin
          u       <= u_c;
          sat     <= clip_hi || clip_lo;
          u_ch    <= ch_p0;
          u_valid <= 1'b1;
          state   <= OUT;
        end
        OUT: if (u_ready) begin
          u_valid <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-channel state commit; a clear on the same edge overrides the commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < CH; n++) begin
        integ[n]  <= '0;
        e_prev[n] <= '0;
      end
    end else if (ena) begin
      for (int n = 0; n < CH; n++) begin
        if (state == CALC && ch_p0 == CH_W'(n)) begin
          e_prev[n] <= e_p0;
          if (i_commit)
            integ[n] <= i_c;
        end
        if (clr[n]) begin
          integ[n]  <= '0;
          e_prev[n] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pid_multichannel.sv
// Self-checking bench for pid_multichannel against an integer reference model.
module tb_pid_multichannel;

  localparam int CH     = 2;
  localparam int DATA_W = 6;
  localparam int GAIN_W = 6;
  localparam int ACC_W  = 12;
  localparam int SHIFT  = 0;
  localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1;
  localparam int U_HI   = (1 << (DATA_W - 1)) - 1;
  localparam int U_LO   = -(1 << (DATA_W - 1));
  localparam int A_HI   = (1 << (ACC_W - 1)) - 1;
  localparam int A_LO   = -(1 << (ACC_W - 1));

  logic                  clk;
  logic                  rst_n;
  logic                  ena;
  logic                  e_valid;
  logic                  e_ready;
  logic [CH_W-1:0]       e_ch;
  logic [DATA_W-1:0]     e;
  logic [2*CH-1:0]       mode;
  logic [CH*GAIN_W-1:0]  K_p, K_i, K_d;
  logic [CH-1:0]         clr;
  logic                  u_valid;
  logic                  u_ready;
  logic [CH_W-1:0]       u_ch;
  logic [DATA_W-1:0]     u;
  logic                  sat;

  pid_multichannel #(.CH(CH), .DATA_W(DATA_W), .GAIN_W(GAIN_W), .ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .e_valid(e_valid), .e_ready(e_ready),
    .e_ch(e_ch), .e(e), .mode(mode), .K_p(K_p), .K_i(K_i), .K_d(K_d), .clr(clr),
    .u_valid(u_valid), .u_ready(u_ready), .u_ch(u_ch), .u(u), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  int I_m  [CH];
  int ep_m [CH];

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic model_reset();
    for (int n = 0; n < CH; n++) begin
      I_m[n]  = 0;
      ep_m[n] = 0;
    end
  endtask

  // Reference behaviour of one sample: returns result and clip flag, updates channel state
  task automatic model_step(input int ch, input int ev, input int m, input int kp, input int ki,
                            input int kd, output int eu, output bit es);
    int c, diff, ic, s, v;
    c    = (ch >= CH) ? CH - 1 : ch;
    diff = ev - ep_m[c];
    ic   = clampi(I_m[c] + ev, A_LO, A_HI);
    s    = kp * ev;
    if (m & 1) s += ki * ic;
    if (m & 2) s += kd * diff;
    v    = s >>> SHIFT;
    eu   = clampi(v, U_LO, U_HI);
    es   = (eu != v);
    ep_m[c] = ev;
    if ((m & 1) && !(es && ((v > U_HI && ev > 0) || (v < U_LO && ev < 0))))
      I_m[c] = ic;
  endtask

  // Present one sample and collect the result; other channels' fields are randomised
  task automatic run_sample(input int sch, input int se, input int sm, input int skp, input int ski,
                            input int skd, input bit release_out, output int ou, output logic os,
                            output logic [CH_W-1:0] och, output logic ov1, output logic ov2);
    int w;
    ou = 0; os = 1'bx; och = 'x; ov1 = 1'bx; ov2 = 1'bx;
    @(negedge clk);
    w = 0;
    while (e_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (e_ready !== 1'b1) begin
      total++;
      $display("FAIL e_ready_timeout: e_ready=%b after %0d cycles, required 1", e_ready, w);
      return;
    end
    mode = (2*CH)'($urandom);
    K_p  = (CH*GAIN_W)'({$urandom, $urandom});
    K_i  = (CH*GAIN_W)'({$urandom, $urandom});
    K_d  = (CH*GAIN_W)'({$urandom, $urandom});
    e_ch = sch[CH_W-1:0];
    e    = se[DATA_W-1:0];
    mode[sch*2 +: 2]          = sm[1:0];
    K_p[sch*GAIN_W +: GAIN_W] = skp[GAIN_W-1:0];
    K_i[sch*GAIN_W +: GAIN_W] = ski[GAIN_W-1:0];
    K_d[sch*GAIN_W +: GAIN_W] = skd[GAIN_W-1:0];
    e_valid = 1'b1;
    @(negedge clk);
    e_valid = 1'b0;
    ov1 = u_valid;
    @(negedge clk);
    ov2 = u_valid;
    ou  = int'($signed(u));
    os  = sat;
    och = u_ch;
    if (release_out) begin
      u_ready = 1'b1;
      @(negedge clk);
      u_ready = 1'b0;
    end
  endtask

  int              ou, eu;
  logic            os, ov1, ov2;
  logic [CH_W-1:0] och;
  bit              es;

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; e_valid = 1'b0; u_ready = 1'b0; clr = '0;
    e_ch = '0; e = '0; mode = '0; K_p = '0; K_i = '0; K_d = '0;
    model_reset();
    repeat (3) @(negedge clk);
    total++; if (u_valid !== 1'b0) $display("FAIL rst_u_valid: got %b want 0", u_valid); else passed++;
    total++; if (u !== '0)         $display("FAIL rst_u: got %0d want 0", u);             else passed++;
    total++; if (sat !== 1'b0)     $display("FAIL rst_sat: got %b want 0", sat);          else passed++;
    total++; if (u_ch !== '0)      $display("FAIL rst_u_ch: got %0d want 0", u_ch);       else passed++;
    total++; if (e_ready !== 1'b0) $display("FAIL rst_e_ready: got %b want 0", e_ready);  else passed++;
    rst_n = 1'b1;
    #1;
    total++; if (e_ready !== 1'b0) $display("FAIL rst_e_ready_pre_edge: got %b want 0", e_ready); else passed++;
    @(negedge clk);
    total++; if (e_ready !== 1'b1) $display("FAIL rst_e_ready_post_edge: got %b want 1", e_ready); else passed++;
  endtask

  task automatic test_p_mode();
    run_sample(0, 5, 0, 2, 0, 0, 1'b1, ou, os, och, ov1, ov2);
    model_step(0, 5, 0, 2, 0, 0, eu, es);
    total++; if (ov1 !== 1'b0) $display("FAIL p_latency_early: u_valid=%b one clock after accept, want 0", ov1); else passed++;
    total++; if (ov2 !== 1'b1) $display("FAIL p_latency: u_valid=%b two clocks after accept, want 1", ov2); else passed++;
    total++; if (ou != 10)     $display("FAIL p_u: got %0d want 10", ou);   else passed++;
    total++; if (os !== 1'b0)  $display("FAIL p_sat: got %b want 0", os);   else passed++;
    total++; if (och !== '0)   $display("FAIL p_u_ch: got %0d want 0", och); else passed++;
    run_sample(0, 5, 0, 10, 0, 0, 1'b1, ou, os, och, ov1, ov2);
    model_step(0, 5, 0, 10, 0, 0, eu, es);
    total++; if (ou != 31)    $display("FAIL p_clip_hi_u: got %0d want 31", ou); else passed++;
    total++; if (os !== 1'b1) $display("FAIL p_clip_hi_sat: got %b want 1", os); else passed++;
    run_sample(0, -5, 0, 10, 0, 0, 1'b1, ou, os, och, ov1, ov2);
    model_step(0, -5, 0, 10, 0, 0, eu, es);
    total++; if (ou != -32)   $display("FAIL p_clip_lo_u: got %0d want -32", ou); else passed++;
    total++; if (os !== 1'b1) $display("FAIL p_clip_lo_sat: got %b want 1", os);  else passed++;
  endtask

  task automatic test_pi_clear();
    int exp_u [4] = '{3, 6, 9, 3};
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        @(negedge clk);
        clr = 2'b01;
        @(negedge clk);
        clr = '0;
        I_m[0] = 0; ep_m[0] = 0;
      end
      run_sample(0, 3, 1, 0, 1, 0, 1'b1, ou, os, och, ov1, ov2);
      model_step(0, 3, 1, 0, 1, 0, eu, es);
      total++; if (ou != exp_u[k]) $display("FAIL pi_u[%0d]: got %0d want %0d", k, ou, exp_u[k]); else passed++;
    end
  endtask

  task automatic test_pd_interleave();
    run_sample(1, 4, 2, 0, 0, 2, 1'b1, ou, os, och, ov1, ov2);
    model_step(1, 4, 2, 0, 0, 2, eu, es);
    total++; if (ou != 8)      $display("FAIL pd_u0: got %0d want 8", ou);    else passed++;
    total++; if (och !== 1'b1) $display("FAIL pd_u_ch: got %0d want 1", och); else passed++;
    run_sample(0, 7, 3, 1, 2, 3, 1'b1, ou, os, och, ov1, ov2);
    model_step(0, 7, 3, 1, 2, 3, eu, es);
    total++; if (ou != eu) $display("FAIL pd_interleaved_ch0: got %0d want %0d", ou, eu); else passed++;
    run_sample(0, -9, 2, 0, 0, 1, 1'b1, ou, os, och, ov1, ov2);
    model_step(0, -9, 2, 0, 0, 1, eu, es);
    run_sample(1, 10, 2, 0, 0, 2, 1'b1, ou, os, och, ov1, ov2);
    model_step(1, 10, 2, 0, 0, 2, eu, es);
    total++; if (ou != 12)    $display("FAIL pd_u1: got %0d want 12", ou); else passed++;
    total++; if (os !== 1'b0) $display("FAIL pd_sat: got %b want 0", os); else passed++;
  endtask

  task automatic test_antiwindup();
    int ev  [4] = '{20, 20, 20, -20};
    int xu  [4] = '{20, 31, 31, 0};
    bit xs  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    @(negedge clk);
    clr = 2'b01;
    @(negedge clk);
    clr = '0;
    I_m[0] = 0; ep_m[0] = 0;
    for (int k = 0; k < 4; k++) begin
      run_sample(0, ev[k], 1, 0, 1, 0, 1'b1, ou, os, och, ov1, ov2);
      model_step(0, ev[k], 1, 0, 1, 0, eu, es);
      total++; if (ou != xu[k])  $display("FAIL aw_u[%0d]: got %0d want %0d", k, ou, xu[k]); else passed++;
      total++; if (os !== xs[k]) $display("FAIL aw_sat[%0d]: got %b want %b", k, os, xs[k]); else passed++;
    end
  endtask

  task automatic test_ena_freeze();
    run_sample(1, -3, 0, 1, 0, 0, 1'b0, ou, os, och, ov1, ov2);
    model_step(1, -3, 0, 1, 0, 0, eu, es);
    total++; if (ou != -3) $display("FAIL ena_u: got %0d want -3", ou); else passed++;
    ena = 1'b0;
    u_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (u_valid !== 1'b1) $display("FAIL ena_hold_valid[%0d]: got %b want 1", k, u_valid); else passed++;
      total++; if (e_ready !== 1'b0) $display("FAIL ena_e_ready[%0d]: got %b want 0", k, e_ready); else passed++;
    end
    ena = 1'b1;
    @(negedge clk);
    u_ready = 1'b0;
    total++; if (u_valid !== 1'b0) $display("FAIL ena_release: got %b want 0", u_valid); else passed++;
  endtask

  task automatic test_backpressure_reset();
    int held;
    run_sample(0, 6, 0, 3, 0, 0, 1'b0, ou, os, och, ov1, ov2);
    model_step(0, 6, 0, 3, 0, 0, eu, es);
    held = ou;
    total++; if (ou != 18) $display("FAIL bp_u: got %0d want 18", ou); else passed++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if (int'($signed(u)) != held || u_valid !== 1'b1)
        $display("FAIL bp_hold[%0d]: u=%0d u_valid=%b want u=%0d u_valid=1", k, $signed(u), u_valid, held);
      else passed++;
      total++; if (e_ready !== 1'b0) $display("FAIL bp_e_ready[%0d]: got %b want 0", k, e_ready); else passed++;
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (u_valid !== 1'b0) $display("FAIL async_rst_valid: got %b want 0", u_valid); else passed++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_sample(0, 3, 1, 0, 1, 0, 1'b1, ou, os, och, ov1, ov2);
    model_step(0, 3, 1, 0, 1, 0, eu, es);
    total++; if (ou != 3) $display("FAIL post_rst_pi_u: got %0d want 3", ou); else passed++;
  endtask

  task automatic test_random();
    int rc, re, rm, rkp, rki, rkd;
    for (int k = 0; k < 40; k++) begin
      rc  = $urandom_range(0, CH - 1);
      re  = int'($urandom_range(0, 63)) - 32;
      rm  = $urandom_range(0, 3);
      rkp = $urandom_range(0, 63);
      rki = $urandom_range(0, 63);
      rkd = $urandom_range(0, 63);
      run_sample(rc, re, rm, rkp, rki, rkd, 1'b1, ou, os, och, ov1, ov2);
      model_step(rc, re, rm, rkp, rki, rkd, eu, es);
      total++; if (ou != eu) $display("FAIL rand_u[%0d]: ch=%0d e=%0d mode=%0d got %0d want %0d", k, rc, re, rm, ou, eu); else passed++;
      total++; if (os !== es) $display("FAIL rand_sat[%0d]: got %b want %b", k, os, es); else passed++;
      total++; if (int'(och) != rc) $display("FAIL rand_u_ch[%0d]: got %0d want %0d", k, och, rc); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_p_mode();
    test_pi_clear();
    test_pd_interleave();
    test_antiwindup();
    test_ena_freeze();
    test_backpressure_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pid_multichannel.md
PID_MULTICHANNEL -- requirements
Module: pid_multichannel

Interface
REQ-001 SHALL provide parameter CH, default 2: number of independent PID channels, 1..8.
REQ-002 SHALL provide parameter DATA_W, default 6: signed width of error e and output u.
REQ-003 SHALL provide parameter GAIN_W, default 6: unsigned width of each gain.
REQ-004 SHALL provide parameter ACC_W, default 12: signed width of each channel's integrator.
REQ-005 SHALL provide parameter SHIFT, default 0: arithmetic right shift applied to the gain sum.
REQ-006 SHALL provide ports: clk  in  1  sole clock, rising edge.
REQ-007 SHALL provide rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-008 SHALL provide ena  in  1  enable; low freezes all state and outputs.
REQ-009 SHALL provide e_valid / e_ready  in / out  1 / 1  error input handshake.
REQ-010 SHALL provide e_ch  in  clog2(CH) (min 1)  channel of the presented sample.
REQ-011 SHALL provide e  in  DATA_W  signed error sample.
REQ-012 SHALL provide mode  in  2*CH  per-channel mode: 00 P, 01 PI, 10 PD, 11 PID.
REQ-013 SHALL provide K_p, K_i, K_d  in  CH*GAIN_W each  per-channel unsigned gains; channel n occupies bits [n*GAIN_W +: GAIN_W].
REQ-014 SHALL provide clr  in  CH  per-channel synchronous clear of integrator and previous error.
REQ-015 SHALL provide u_valid / u_ready  out / in  1 / 1  result output handshake.
REQ-016 SHALL provide u_ch  out  clog2(CH)  channel of the result; u  out  DATA_W  signed result; sat  out  1  result was clipped.

Function
REQ-017 SHALL implement FSM IDLE -> CALC -> OUT -> IDLE; e_ready = 1 only in IDLE with ena=1.
REQ-018 SHALL capture e, e_ch, mode, gains on the edge where e_valid & e_ready; IDLE->CALC.
REQ-019 SHALL in CALC compute: diff = e - e_prev[ch] (DATA_W+1 bits); I_c = I[ch] + e, saturated to ACC_W.
REQ-020 SHALL form sum = Kp*e + Ki*I_c + Kd*diff at full width with no overflow, where disabled terms (per mode) are zero.
REQ-021 SHALL produce u = sum >>> SHIFT saturated to the DATA_W signed range; sat=1 iff clipping occurred.
REQ-022 SHALL on CALC->OUT (the edge after CALC) register u, u_ch, sat, assert u_valid, and commit e_prev[ch] = e.
REQ-023 SHALL commit I[ch] = I_c only in PI/PID modes, and not when sat=1 and sign(e) equals clip direction (conditional-integration anti-windup).
REQ-024 SHALL hold u_valid, u, u_ch, sat stable in OUT until u_valid & u_ready, then return to IDLE; latency from accept edge to u_valid high = 2 clocks.
REQ-025 SHALL treat e_ch >= CH as channel CH-1.
REQ-026 SHALL apply clr[n] at the next edge; if clr[n] coincides with the commit for channel n, clr wins (I and e_prev end at 0).
REQ-027 SHALL, with ena=0, hold FSM, state, outputs; e_ready=0; handshakes are ignored.

Reset
REQ-028 SHALL on rst_n low immediately force: FSM IDLE, u_valid=0, u=0, u_ch=0, sat=0, e_ready=0 while in reset, all I[n]=0, all e_prev[n]=0; in-flight sample discarded.
REQ-029 SHALL raise e_ready on the first edge after rst_n deasserts with ena=1.

Verification (defaults CH=2, DATA_W=6, GAIN_W=6, ACC_W=12, SHIFT=0)
REQ-030 P mode ch0, K_p=2, e=5 -> u=10, sat=0, u_valid exactly 2 clocks after accept.
REQ-031 P mode ch0, K_p=10, e=5 -> u=31, sat=1; e=-5 -> u=-32, sat=1.
REQ-032 PI mode ch0, K_p=0, K_i=1, samples e=3,3,3 -> u=3,6,9; then clr[0], e=3 -> u=3.
REQ-033 PD mode ch1, K_d=2, e=4 then e=10 -> u=8 then 12; ch0 samples interleaved do not alter ch1 results.
REQ-034 PI mode, K_i=1, e=20 repeatedly -> u clips to 31, sat=1, integrator stops growing; e=-20 then brings u down within one sample.
REQ-035 u_ready held low 5 clocks -> u stable and e_ready=0 throughout; rst_n pulsed in OUT -> u_valid=0 asynchronously, next PI sample on ch0 with e=3 yields u=3.
